// File: rtl/inv_butterfly_pipe.sv
// Gentleman-Sande inverse-NTT butterfly: a0 = (x0+x1)/2 mod Q, a1 = (x0-x1)*w/2 mod Q (halving optional).
// Latency: 3 clk from input handshake to out_valid; throughput 1 pair/clk.
// Backpressure: whole pipe stalls when out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   in_valid/in_ready       input handshake for x0, x1, w (w is the inverse twiddle)
//   out_valid/out_ready     output handshake for a0, a1 (both in [0,Q))
//   pair_count              output handshakes since reset, wrapping
//   busy                    any pipeline stage holds valid data
module inv_butterfly_pipe #(
  parameter int BITS  = 32,
  parameter int Q     = 5,
  parameter bit HALVE = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  x0,
  input  logic [BITS-1:0]  x1,
  input  logic [BITS-1:0]  w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  a0,
  output logic [BITS-1:0]  a1,
  output logic [CNT_W-1:0] pair_count,
  output logic             busy
);

  localparam logic [BITS-1:0] QB = BITS'(Q);

  logic            adv;
  logic            v1, v2, v3;
  logic [BITS-1:0] s1, d1, w1;
  logic [BITS-1:0] s2, p2;

  // Stage-1 combinational results
  logic [BITS-1:0] xr0, xr1;
  logic [BITS:0]   sum_w;
  logic [BITS-1:0] s_n, d_n;
  // Stage-2 combinational result
  logic [BITS-1:0] p_n;

  // Multiply by 2^-1 mod Q: an odd residue becomes even by adding Q (odd),
  // so the shift is exact. One extra bit holds v+Q.
  function automatic logic [BITS-1:0] halve_mod(input logic [BITS-1:0] v);
    logic [BITS:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, QB}) : {1'b0, v};
    return BITS'(t >> 1);
  endfunction

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign busy      = v1 || v2 || v3;

  // Inputs may exceed Q, so reduce before the add/sub; after reduction a
  // single conditional correction is enough for both sum and difference.
  always_comb begin
    xr0   = x0 % QB;
    xr1   = x1 % QB;
    sum_w = {1'b0, xr0} + {1'b0, xr1};
    s_n   = (sum_w >= {1'b0, QB}) ? (sum_w[BITS-1:0] - QB) : sum_w[BITS-1:0];
    d_n   = (xr0 >= xr1) ? (xr0 - xr1) : (xr0 + (QB - xr1));
  end

  // Full-width product; w is not pre-reduced, the final mod handles it.
  always_comb begin
    p_n = BITS'(({{BITS{1'b0}}, d1} * {{BITS{1'b0}}, w1}) % {{BITS{1'b0}}, QB});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      s1         <= '0;
      d1         <= '0;
      w1         <= '0;
      s2         <= '0;
      p2         <= '0;
      a0         <= '0;
      a1         <= '0;
      pair_count <= '0;
    end else begin
      if (adv) begin
        // Valids shift every advance so bubbles travel with the data.
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
        if (in_valid) begin
          s1 <= s_n;
          d1 <= d_n;
          w1 <= w;
        end
        if (v1) begin
          s2 <= s1;
          p2 <= p_n;
        end
        if (v2) begin
          a0 <= HALVE ? halve_mod(s2) : s2;
          a1 <= HALVE ? halve_mod(p2) : p2;
        end
      end
      if (v3 && out_ready) begin
        pair_count <= pair_count + CNT_W'(1);
      end
    end
  end

endmodule
